// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
// Module      : sequential_divider
// Description : Iterative unsigned restoring divider. Captures a
//               dividend/divisor pair on start, resolves one quotient bit per
//               clock (MSB first) and presents the quotient and remainder
//               with a one-cycle done pulse. A zero divisor short-circuits
//               straight to DONE with an all-ones quotient and div_by_zero set.
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Counter only has to reach WIDTH-1; one spare bit keeps it safe for any WIDTH
    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after WIDTH steps this register holds the complete quotient.
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_divisor;
    // The kept partial remainder is always below the divisor and so fits in
    // WIDTH bits; the extra sign bit only exists on the trial value below.
    logic [WIDTH-1:0]   r_partial;
    logic [c_CNT_W-1:0] r_count;

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference when its sign bit is clear, otherwise restore.
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_next_rem;
    logic [WIDTH-1:0]   w_next_shift;

    assign w_shifted    = {r_partial, r_shift[WIDTH-1]};
    assign w_diff       = w_shifted - {1'b0, r_divisor};
    assign w_qbit       = ~w_diff[WIDTH];
    assign w_next_rem   = w_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_next_shift = {r_shift[WIDTH-2:0], w_qbit};

    // Control FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_partial   <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_partial <= '0;
                        r_count   <= '0;
                        busy      <= 1'b1;
                        if (divisor == '0) begin
                            // No iterations needed: report the fixed result now
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            r_state     <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_partial <= w_next_rem;
                    r_shift   <= w_next_shift;
                    r_count   <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        // Final bit resolved this edge: publish the results
                        quotient  <= w_next_shift;
                        remainder <= w_next_rem;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
